// File: rtl/mdu_core_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op codes, FSM states, latencies.
package mdu_core_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mduOp_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mduState_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Codes 6 and 7 are reserved and never start anything.
  function automatic logic mduOpValid(logic [2:0] op);
    return op <= MDU_MTLO;
  endfunction

endpackage

// File: rtl/mdu_core_divider.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient/remainder.
module mdu_divider (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        divZero_o
);

  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] safeB;
  logic [31:0] magQ;
  logic [31:0] magR;

  assign negA      = signed_i & dividend_i[31];
  assign negB      = signed_i & divisor_i[31];
  assign magA      = negA ? (~dividend_i + 32'd1) : dividend_i;
  assign magB      = negB ? (~divisor_i + 32'd1) : divisor_i;
  assign divZero_o = (divisor_i == 32'd0);

  // Substitute 1 for a zero divisor so the datapath stays defined; the caller ignores the result.
  assign safeB = divZero_o ? 32'd1 : magB;
  assign magQ  = magA / safeB;
  assign magR  = magA % safeB;

  assign quot_o = (negA ^ negB) ? (~magQ + 32'd1) : magQ;
  assign rem_o  = negA ? (~magR + 32'd1) : magR;

endmodule

// File: rtl/mdu_core.sv
// MIPS-style multiply/divide unit: HI/LO registers with fixed-latency MULT/DIV and MTHI/MTLO.
module mdu_core
  import mdu_core_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  mduState_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;

  logic        accept;
  logic        signedMul;
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        divZero;

  mdu_divider u_divider (
    .dividend_i (a),
    .divisor_i  (b),
    .signed_i   (op == MDU_DIV),
    .quot_o     (quot),
    .rem_o      (rem),
    .divZero_o  (divZero)
  );

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign signedMul = (op == MDU_MULT);
  assign mulA      = {{32{signedMul & a[31]}}, a};
  assign mulB      = {{32{signedMul & b[31]}}, b};
  assign product   = mulA * mulB;

  assign accept = start && !cancel && (state_q == MDU_IDLE) && mduOpValid(op);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            MDU_MULT, MDU_MULTU: begin
              {pendHi_d, pendLo_d} = product;
              state_d              = MDU_RUN;
              cnt_d                = MULT_LOAD;
            end
            MDU_DIV, MDU_DIVU: begin
              // A zero divisor re-commits the current HI/LO, which cannot change while running.
              pendHi_d = divZero ? hi_q : rem;
              pendLo_d = divZero ? lo_q : quot;
              state_d  = MDU_RUN;
              cnt_d    = DIV_LOAD;
            end
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        if (cnt_q == 4'd0) begin
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pendHi_q <= 32'd0;
      pendLo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

  assign busy  = (state_q == MDU_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage request pulse, valid for one cycle per instruction.
REQ-006 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-007 cancel  input  1  E-stage instruction flushed this cycle; suppresses start.
REQ-008 a  input  32  rs operand, already forwarded.
REQ-009 b  input  32  rt operand, already forwarded.
REQ-010 rd_hi  input  1  read select for rdata: 1 HI, 0 LO (MFHI/MFLO).
REQ-011 busy  output  1  multi-cycle operation in progress; hazard unit stalls D when (start || busy) and the D instruction is an MDU instruction.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.
REQ-014 rdata  output  32  combinational mux of hi/lo by rd_hi.

Function
REQ-015 The block SHALL implement an FSM with states IDLE and RUN plus a 4-bit down-counter cnt.
REQ-016 An accepted start SHALL require start=1, cancel=0, state IDLE and op in 0-5.
REQ-017 start while in RUN SHALL be ignored.
REQ-018 start with op 6-7 SHALL be ignored.
REQ-019 Accepted MTHI SHALL write hi<=a at that edge; state SHALL stay IDLE; busy SHALL remain 0.
REQ-020 Accepted MTLO SHALL write lo<=a at that edge; state SHALL stay IDLE; busy SHALL remain 0.
REQ-021 Accepted MULT/MULTU/DIV/DIVU SHALL latch the 64-bit result into pending registers, enter RUN and load cnt with MULT_CYCLES-1 or DIV_CYCLES-1.
REQ-022 MULT SHALL produce the signed 32x32->64 product; MULTU the unsigned product; the pending result is {hi,lo}.
REQ-023 DIV/DIVU SHALL produce pending lo=quotient and hi=remainder, signed (truncate toward zero, remainder takes the dividend's sign) or unsigned respectively.
REQ-024 DIV/DIVU with b==0 SHALL run the full latency and leave hi/lo unchanged.
REQ-025 busy SHALL be 1 exactly while state is RUN, i.e. for MULT_CYCLES (DIV_CYCLES) consecutive cycles starting the cycle after acceptance.
REQ-026 In RUN with cnt==0, the next edge SHALL commit the pending result to hi/lo and return to IDLE; otherwise cnt SHALL decrement.
REQ-027 hi/lo SHALL hold their old values throughout RUN, so a read during RUN returns pre-operation values.
REQ-028 A new start SHALL be accepted in the first cycle busy is 0 after commit (back-to-back, no bubble).
REQ-029 Parameters SHALL be limited to 1..16; a value of 1 gives one busy cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, cnt=0, busy=0, hi=0, lo=0 and pending registers to 0.
REQ-031 Reset asserted mid-RUN SHALL discard the pending result with no commit.
REQ-032 Deassertion SHALL take effect at the next rising edge; start on that edge SHALL be accepted normally.

Structure
REQ-033 Op encodings (MDU_MULT..MDU_MTLO), the state encodings and the default latencies SHALL live in the shared pipeline definitions package, also used by the decoder and the hazard unit.
REQ-034 One sub-module, mdu_divider (combinational signed/unsigned 32-bit quotient/remainder with a div-by-zero flag), is natural; multiplication SHALL stay inline.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; rdata tracks rd_hi.
REQ-038 DIVU with b=0 and hi=0x11, lo=0x22 preloaded by MTHI/MTLO -> busy 10 cycles, then hi=0x11, lo=0x22.
REQ-039 MULT start with cancel=1 -> busy stays 0 and hi/lo unchanged; a start pulse mid-RUN is ignored and the cycle count is unaffected.
REQ-040 reset_n pulled low at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately; after release, MTLO a=5 -> lo=5 next edge.
